// File: rtl/nibble_serial_subtractor.sv
// Serial subtractor diff = a - b - borrow_in, one 4-bit nibble per cycle LSB first, dual-rail borrow.
// Latency NIB cycles from accept to out_valid; result held in DONE until out_ready, no input accepted meanwhile.
// Optional signed-overflow output enabled by defining SUB_SIGNED_OVF_EN.
module nibble_serial_subtractor #(
    parameter int WIDTH = 16,
    parameter int NIB   = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
`ifdef SUB_SIGNED_OVF_EN
    output logic             ovf,
`endif
    output logic             borrow_out
);

    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               bt_q, bt_d;
    logic               bf_q, bf_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [4:0]         sum;
    logic               last;
`ifdef SUB_SIGNED_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        idx_d   = idx_q;
        bt_d    = bt_q;
        bf_d    = bf_q;
`ifdef SUB_SIGNED_OVF_EN
        ovf_d   = ovf_q;
`endif
        // Operands shift right each RUN cycle so the active nibble is always [3:0];
        // the bf rail is the "no borrow" rail, i.e. the adder carry-in.
        sum  = {1'b0, a_q[3:0]} + {1'b0, ~b_q[3:0]} + {4'b0000, bf_q};
        last = (idx_q == IDX_W'(NIB - 1));

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    idx_d   = '0;
                    bt_d    = borrow_in;
                    bf_d    = ~borrow_in;
                end
            end
            RUN: begin
                a_d    = a_q >> 4;
                b_d    = b_q >> 4;
                diff_d = WIDTH'({sum[3:0], diff_q} >> 4);
                bt_d   = ~sum[4];
                bf_d   = sum[4];
                idx_d  = idx_q + IDX_W'(1);
                if (last) begin
                    state_d = DONE;
`ifdef SUB_SIGNED_OVF_EN
                    ovf_d   = (a_q[3] ^ b_q[3]) & (a_q[3] ^ sum[3]);
`endif
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            diff_q      <= '0;
            idx_q       <= '0;
            bt_q        <= 1'b0;
            bf_q        <= 1'b1;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            diff_q      <= diff_d;
            idx_q       <= idx_d;
            bt_q        <= bt_d;
            bf_q        <= bf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef SUB_SIGNED_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign diff       = diff_q;
    assign borrow_out = bt_q;
`ifdef SUB_SIGNED_OVF_EN
    assign ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Randomized and directed bench for nibble_serial_subtractor (WIDTH=16) against an arithmetic reference.
module tb_nibble_serial_subtractor;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic         borrow_in, borrow_out;
    logic [W-1:0] a, b, diff;
    logic         ov_cap;
`ifdef SUB_SIGNED_OVF_EN
    logic         ovf;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    nibble_serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
`ifdef SUB_SIGNED_OVF_EN
        .ovf        (ovf),
`endif
        .borrow_out (borrow_out)
    );

    // {borrow_out, diff} as plain unsigned arithmetic one bit wider than the operands
    function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        logic [W:0] r;
        r = {1'b0, x} - {1'b0, y} - (W+1)'(bi);
        return r;
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
        int r;
        r = int'($signed(x)) - int'($signed(y));
        return (r > 32767) || (r < -32768);
    endfunction

    // Issues one op from IDLE, waits for the result, captures it, then handshakes after 'hold' stall cycles.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi, input int hold,
                          output logic [W-1:0] d, output logic bo, output int lat);
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        borrow_in = bi;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        a         = W'($urandom);
        b         = W'($urandom);
        borrow_in = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        d  = diff;
        bo = borrow_out;
`ifdef SUB_SIGNED_OVF_EN
        ov_cap = ovf;
`endif
        repeat (hold) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; borrow_in = 1'b0; ov_cap = 1'b0;
        #12;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests++; if (diff !== 16'h0) begin fails++; $display("FAIL reset_diff got %h want 0000", diff); end
        tests++; if (borrow_out !== 1'b0) begin fails++; $display("FAIL reset_borrow got %b want 0", borrow_out); end
`ifdef SUB_SIGNED_OVF_EN
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", ovf); end
`endif
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [W-1:0] xa[3] = '{16'h1234, 16'h0000, 16'h0010};
        logic [W-1:0] xb[3] = '{16'h0234, 16'h0001, 16'h0000};
        logic         xi[3] = '{1'b0, 1'b0, 1'b1};
        logic [W-1:0] d;
        logic [W:0]   e;
        logic         bo;
        int           lat;
        for (int i = 0; i < 3; i++) begin
            run_op(xa[i], xb[i], xi[i], 0, d, bo, lat);
            e = ref_sub(xa[i], xb[i], xi[i]);
            tests++; if (lat != 4) begin fails++; $display("FAIL directed%0d_latency got %0d want 4", i, lat); end
            tests++; if (d !== e[W-1:0]) begin fails++; $display("FAIL directed%0d_diff got %h want %h", i, d, e[W-1:0]); end
            tests++; if (bo !== e[W]) begin fails++; $display("FAIL directed%0d_borrow got %b want %b", i, bo, e[W]); end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] x, y, d;
        logic [W:0]   e;
        logic         bi, bo;
        int           lat;
        for (int i = 0; i < 40; i++) begin
            x  = W'($urandom);
            y  = (i % 5 == 0) ? x : W'($urandom);
            bi = 1'($urandom);
            run_op(x, y, bi, $urandom_range(0, 3), d, bo, lat);
            e = ref_sub(x, y, bi);
            tests++; if (d !== e[W-1:0] || lat != 4) begin
                fails++; $display("FAIL random%0d_diff got %h lat %0d want %h lat 4", i, d, lat, e[W-1:0]);
            end
            tests++; if (bo !== e[W]) begin fails++; $display("FAIL random%0d_borrow got %b want %b", i, bo, e[W]); end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] d;
        logic         bo;
        int           lat;
        in_valid = 1'b1; a = 16'h1234; b = 16'h0234; borrow_in = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        in_valid = 1'b1; a = 16'hFFFF; b = 16'h0000; borrow_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            tests++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                fails++; $display("FAIL stall%0d_handshake got ov=%b ir=%b want ov=1 ir=0", i, out_valid, in_ready);
            end
            tests++; if (diff !== 16'h1000 || borrow_out !== 1'b0) begin
                fails++; $display("FAIL stall%0d_hold got %h/%b want 1000/0", i, diff, borrow_out);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL stall_release got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
        end
        run_op(16'h00FF, 16'h0100, 1'b0, 0, d, bo, lat);
        tests++; if (d !== 16'hFFFF || bo !== 1'b1) begin
            fails++; $display("FAIL stall_next_op got %h/%b want ffff/1", d, bo);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] d;
        logic         bo;
        int           lat;
        in_valid = 1'b1; a = 16'hABCD; b = 16'h1234; borrow_in = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++; $display("FAIL midrst_handshake got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid);
        end
        tests++; if (diff !== 16'h0 || borrow_out !== 1'b0) begin
            fails++; $display("FAIL midrst_clear got %h/%b want 0000/0", diff, borrow_out);
        end
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(16'h5000, 16'h0001, 1'b1, 1, d, bo, lat);
        tests++; if (d !== 16'h4FFE || bo !== 1'b0 || lat != 4) begin
            fails++; $display("FAIL midrst_next_op got %h/%b lat %0d want 4ffe/0 lat 4", d, bo, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [W:0] q[$];
        logic [W:0] e;
        logic       prev_rdy;
        int         last_acc, nacc;
        last_acc = -1; nacc = 0;
        out_ready = 1'b1; in_valid = 1'b1;
        a = W'($urandom); b = W'($urandom); borrow_in = 1'($urandom);
        prev_rdy = in_ready;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(posedge clk); #1;
            if (prev_rdy && in_valid) begin
                q.push_back(ref_sub(a, b, borrow_in));
                if (last_acc >= 0) begin
                    tests++; if (cyc - last_acc != 6) begin
                        fails++; $display("FAIL b2b_interval got %0d want 6", cyc - last_acc);
                    end
                end
                last_acc = cyc; nacc++;
                a = W'($urandom); b = W'($urandom); borrow_in = 1'($urandom);
            end
            if (out_valid) begin
                tests++;
                if (q.size() == 0) begin
                    fails++; $display("FAIL b2b_spurious got out_valid=1 want no result pending");
                end else begin
                    e = q.pop_front();
                    if ({borrow_out, diff} !== e) begin
                        fails++; $display("FAIL b2b_result got %b/%h want %b/%h", borrow_out, diff, e[W], e[W-1:0]);
                    end
                end
            end
            if (cyc == 48) in_valid = 1'b0;
            prev_rdy = in_ready;
        end
        tests++; if (q.size() != 0 || nacc < 8) begin
            fails++; $display("FAIL b2b_drain got %0d pending %0d accepted want 0 pending >=8 accepted", q.size(), nacc);
        end
        out_ready = 1'b0;
    endtask

`ifdef SUB_SIGNED_OVF_EN
    task automatic test_ovf();
        logic [W-1:0] d, x, y;
        logic         bo;
        int           lat;
        run_op(16'h8000, 16'h0001, 1'b0, 0, d, bo, lat);
        tests++; if (d !== 16'h7FFF || ov_cap !== 1'b1) begin
            fails++; $display("FAIL ovf_min got %h/%b want 7fff/1", d, ov_cap);
        end
        run_op(16'h0005, 16'h0003, 1'b0, 0, d, bo, lat);
        tests++; if (ov_cap !== 1'b0) begin fails++; $display("FAIL ovf_small got %b want 0", ov_cap); end
        for (int i = 0; i < 20; i++) begin
            x = W'($urandom); y = W'($urandom);
            run_op(x, y, 1'b0, 0, d, bo, lat);
            tests++; if (ov_cap !== ref_ovf(x, y)) begin
                fails++; $display("FAIL ovf_rand%0d got %b want %b", i, ov_cap, ref_ovf(x, y));
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
`ifdef SUB_SIGNED_OVF_EN
        test_ovf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
